// File: rtl/ramb_asym_dp_sc.sv
// Single-clock true-dual-port RAM with independently sized A/B widths (power-of-two ratio),
// per-port write modes, optional output pipeline and a registered collision flag.
module ramb_asym_dp_sc #(
    parameter int unsigned TOTAL_BITS      = 16384,
    parameter int unsigned WIDTH_A         = 2,
    parameter int unsigned WIDTH_B         = 4,
    parameter string       WRITE_MODE_A    = "WRITE_FIRST",
    parameter string       WRITE_MODE_B    = "WRITE_FIRST",
    parameter logic [WIDTH_A-1:0] INIT_A   = '0,
    parameter logic [WIDTH_B-1:0] INIT_B   = '0,
    parameter logic [WIDTH_A-1:0] SRVAL_A  = '0,
    parameter logic [WIDTH_B-1:0] SRVAL_B  = '0,
    parameter int unsigned DO_REG_A        = 0,
    parameter int unsigned DO_REG_B        = 0,
    parameter string       COLLISION_CHECK = "ALL",
    localparam int unsigned AWA = $clog2(TOTAL_BITS / WIDTH_A),
    localparam int unsigned AWB = $clog2(TOTAL_BITS / WIDTH_B)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ENA,
    input  logic               WEA,
    input  logic               SSRA,
    input  logic [AWA-1:0]     ADDRA,
    input  logic [WIDTH_A-1:0] DIA,
    output logic [WIDTH_A-1:0] DOA,
    input  logic               ENB,
    input  logic               WEB,
    input  logic               SSRB,
    input  logic [AWB-1:0]     ADDRB,
    input  logic [WIDTH_B-1:0] DIB,
    output logic [WIDTH_B-1:0] DOB,
    output logic               COLL
);

    localparam int unsigned R     = WIDTH_B / WIDTH_A;
    localparam int unsigned RB    = $clog2(R);
    localparam int unsigned DEPTH = TOTAL_BITS / WIDTH_A;

    localparam bit A_RF   = (WRITE_MODE_A == "READ_FIRST");
    localparam bit A_NC   = (WRITE_MODE_A == "NO_CHANGE");
    localparam bit B_RF   = (WRITE_MODE_B == "READ_FIRST");
    localparam bit B_NC   = (WRITE_MODE_B == "NO_CHANGE");
    localparam bit COLL_EN = (COLLISION_CHECK == "ALL");

    if (TOTAL_BITS == 0 || (TOTAL_BITS & (TOTAL_BITS - 1)) != 0) begin : g_bad_total
        $error("ramb_asym_dp_sc: TOTAL_BITS must be a power of two");
    end
    if (WIDTH_A < 1 || WIDTH_A > 32 || (WIDTH_A & (WIDTH_A - 1)) != 0) begin : g_bad_wa
        $error("ramb_asym_dp_sc: WIDTH_A must be a power of two in 1..32");
    end
    if ((WIDTH_B % WIDTH_A) != 0 || R == 0 || R > 32 || (R & (R - 1)) != 0
        || WIDTH_B > TOTAL_BITS) begin : g_bad_ratio
        $error("ramb_asym_dp_sc: WIDTH_B must be WIDTH_A * 2^k with k in 0..5");
    end
    if (!(WRITE_MODE_A == "WRITE_FIRST" || A_RF || A_NC)) begin : g_bad_mode_a
        $error("ramb_asym_dp_sc: illegal WRITE_MODE_A");
    end
    if (!(WRITE_MODE_B == "WRITE_FIRST" || B_RF || B_NC)) begin : g_bad_mode_b
        $error("ramb_asym_dp_sc: illegal WRITE_MODE_B");
    end
    if (!(COLL_EN || COLLISION_CHECK == "NONE")) begin : g_bad_coll
        $error("ramb_asym_dp_sc: illegal COLLISION_CHECK");
    end

    // Storage is kept in port-A word granularity; a B word is R adjacent A words.
    logic [WIDTH_A-1:0] mem [DEPTH] = '{default: '0};

    logic [AWA-1:0]     base_b;
    logic               overlap;
    logic [WIDTH_A-1:0] rd_a;
    logic [WIDTH_B-1:0] rd_b;
    logic [WIDTH_A-1:0] lat_a;
    logic [WIDTH_A-1:0] pipe_a;
    logic [WIDTH_B-1:0] lat_b;
    logic [WIDTH_B-1:0] pipe_b;
    logic               coll_q;

    assign base_b  = AWA'(ADDRB) << RB;
    assign overlap = (ADDRA >> RB) == AWA'(ADDRB);
    assign rd_a    = mem[ADDRA];

    always_comb begin
        rd_b = '0;
        for (int unsigned i = 0; i < R; i++) begin
            rd_b[i*WIDTH_A +: WIDTH_A] = mem[base_b | AWA'(i)];
        end
    end

    // Port B writes come last so they win on overlapping write/write.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (ENA && WEA) begin
                mem[ADDRA] <= DIA;
            end
            if (ENB && WEB) begin
                for (int unsigned i = 0; i < R; i++) begin
                    mem[base_b | AWA'(i)] <= DIB[i*WIDTH_A +: WIDTH_A];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lat_a <= INIT_A;
        end else if (ENA) begin
            if (SSRA) begin
                lat_a <= SRVAL_A;
            end else if (!WEA || A_RF) begin
                lat_a <= rd_a;
            end else if (!A_NC) begin
                lat_a <= DIA;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lat_b <= INIT_B;
        end else if (ENB) begin
            if (SSRB) begin
                lat_b <= SRVAL_B;
            end else if (!WEB || B_RF) begin
                lat_b <= rd_b;
            end else if (!B_NC) begin
                lat_b <= DIB;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pipe_a <= INIT_A;
            pipe_b <= INIT_B;
            coll_q <= 1'b0;
        end else begin
            pipe_a <= lat_a;
            pipe_b <= lat_b;
            coll_q <= COLL_EN && ENA && ENB && overlap && (WEA || WEB);
        end
    end

    assign DOA  = (DO_REG_A != 0) ? pipe_a : lat_a;
    assign DOB  = (DO_REG_B != 0) ? pipe_b : lat_b;
    assign COLL = coll_q;

endmodule

// File: tb/tb_ramb_asym_dp_sc.sv
// Directed bench for ramb_asym_dp_sc: three differently configured instances share stimulus
// and are checked every cycle against a behavioural memory model plus literal expectations.
module tb_ramb_asym_dp_sc;

    logic        clk = 1'b0;
    logic        rst, ena, wea, ssra, enb, web, ssrb;
    logic [12:0] addra;
    logic [11:0] addrb;
    logic [1:0]  dia;
    logic [3:0]  dib;

    logic [1:0]  act_doa  [3];
    logic [3:0]  act_dob  [3];
    logic        act_coll [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ramb_asym_dp_sc #(.SRVAL_A(2'h3)) u0 (
        .CLK(clk), .RST(rst),
        .ENA(ena), .WEA(wea), .SSRA(ssra), .ADDRA(addra), .DIA(dia), .DOA(act_doa[0]),
        .ENB(enb), .WEB(web), .SSRB(ssrb), .ADDRB(addrb), .DIB(dib), .DOB(act_dob[0]),
        .COLL(act_coll[0]));

    ramb_asym_dp_sc #(.WRITE_MODE_A("READ_FIRST"), .DO_REG_B(1), .INIT_A(2'h1),
                      .INIT_B(4'hA), .SRVAL_B(4'h6)) u1 (
        .CLK(clk), .RST(rst),
        .ENA(ena), .WEA(wea), .SSRA(ssra), .ADDRA(addra), .DIA(dia), .DOA(act_doa[1]),
        .ENB(enb), .WEB(web), .SSRB(ssrb), .ADDRB(addrb), .DIB(dib), .DOB(act_dob[1]),
        .COLL(act_coll[1]));

    ramb_asym_dp_sc #(.WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("READ_FIRST"), .DO_REG_A(1),
                      .SRVAL_A(2'h2), .SRVAL_B(4'h9), .COLLISION_CHECK("NONE")) u2 (
        .CLK(clk), .RST(rst),
        .ENA(ena), .WEA(wea), .SSRA(ssra), .ADDRA(addra), .DIA(dia), .DOA(act_doa[2]),
        .ENB(enb), .WEB(web), .SSRB(ssrb), .ADDRB(addrb), .DIB(dib), .DOB(act_dob[2]),
        .COLL(act_coll[2]));

    // Per-instance configuration; modes: 0 write-first, 1 read-first, 2 no-change.
    int         mode_a [3] = '{0, 1, 2};
    int         mode_b [3] = '{0, 0, 1};
    bit         dreg_a [3] = '{0, 0, 1};
    bit         dreg_b [3] = '{0, 1, 0};
    logic [1:0] ini_a  [3] = '{2'h0, 2'h1, 2'h0};
    logic [3:0] ini_b  [3] = '{4'h0, 4'hA, 4'h0};
    logic [1:0] srv_a  [3] = '{2'h3, 2'h0, 2'h2};
    logic [3:0] srv_b  [3] = '{4'h0, 4'h6, 4'h9};
    bit         cen    [3] = '{1, 1, 0};

    logic [1:0] mmem [8192] = '{default: '0};
    logic [1:0] m_la [3], m_pa [3];
    logic [3:0] m_lb [3], m_pb [3];
    logic       m_coll [3];
    bit         m_ok = 1'b0;
    logic [1:0] m_old_a;
    logic [3:0] m_old_b;

    assign m_old_a = mmem[int'(addra)];
    assign m_old_b = {mmem[int'(addrb) * 2 + 1], mmem[int'(addrb) * 2]};

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_la[k] <= ini_a[k];  m_pa[k] <= ini_a[k];
                m_lb[k] <= ini_b[k];  m_pb[k] <= ini_b[k];
                m_coll[k] <= 1'b0;
            end else begin
                m_pa[k] <= m_la[k];
                m_pb[k] <= m_lb[k];
                if (ena) begin
                    if (ssra)            m_la[k] <= srv_a[k];
                    else if (!wea)       m_la[k] <= m_old_a;
                    else if (mode_a[k] == 0) m_la[k] <= dia;
                    else if (mode_a[k] == 1) m_la[k] <= m_old_a;
                end
                if (enb) begin
                    if (ssrb)            m_lb[k] <= srv_b[k];
                    else if (!web)       m_lb[k] <= m_old_b;
                    else if (mode_b[k] == 0) m_lb[k] <= dib;
                    else if (mode_b[k] == 1) m_lb[k] <= m_old_b;
                end
                m_coll[k] <= cen[k] && ena && enb && (wea || web)
                             && (int'(addra) / 2 == int'(addrb));
            end
        end
        if (!rst) begin
            if (ena && wea) mmem[int'(addra)] <= dia;
            if (enb && web) begin
                mmem[int'(addrb) * 2]     <= dib[1:0];
                mmem[int'(addrb) * 2 + 1] <= dib[3:2];
            end
        end
        if (rst) m_ok <= 1'b1;
    end

    task automatic chk(input string name, input int inst, input logic [3:0] act,
                       input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s u%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_ok) begin
            for (int k = 0; k < 3; k++) begin
                chk("model_doa", k, {2'b00, act_doa[k]}, {2'b00, dreg_a[k] ? m_pa[k] : m_la[k]});
                chk("model_dob", k, act_dob[k], dreg_b[k] ? m_pb[k] : m_lb[k]);
                chk("model_coll", k, {3'b000, act_coll[k]}, {3'b000, m_coll[k]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        ena = 0; wea = 0; ssra = 0; enb = 0; web = 0; ssrb = 0;
    endtask

    task automatic op_a(input logic we, input logic [12:0] a, input logic [1:0] d);
        ena = 1; wea = we; addra = a; dia = d;
    endtask

    task automatic op_b(input logic we, input logic [11:0] a, input logic [3:0] d);
        enb = 1; web = we; addrb = a; dib = d;
    endtask

    initial begin
        rst = 1; addra = '0; addrb = '0; dia = '0; dib = '0;
        idle();
        tick(); tick();
        chk("rst_doa", 0, {2'b00, act_doa[0]}, 4'h0);
        chk("rst_doa", 1, {2'b00, act_doa[1]}, 4'h1);
        chk("rst_dob", 1, act_dob[1], 4'hA);
        rst = 0;

        // Narrow writes assembled into one wide word.
        op_a(1, 13'd0, 2'b01); tick();
        op_a(1, 13'd1, 2'b10); tick();
        idle(); op_b(0, 12'd0, 4'h0); tick();
        chk("t1_dob", 0, act_dob[0], 4'b1001);

        // Wide write seen as narrow words.
        idle(); op_b(1, 12'd5, 4'hC); tick();
        chk("t2_dob_wf", 0, act_dob[0], 4'hC);
        chk("t2_dob_rf", 2, act_dob[2], 4'h0);
        idle(); op_a(0, 13'd10, 2'b00); tick();
        chk("t2_doa10", 0, {2'b00, act_doa[0]}, 4'h0);
        op_a(0, 13'd11, 2'b00); tick();
        chk("t2_doa11", 0, {2'b00, act_doa[0]}, 4'h3);

        // Write modes on port A.
        op_a(1, 13'd3, 2'b01); tick();
        op_a(1, 13'd3, 2'b10); tick();
        chk("t3_doa_rf", 1, {2'b00, act_doa[1]}, 4'h1);
        op_a(0, 13'd3, 2'b00); tick();
        chk("t3_doa_reread", 1, {2'b00, act_doa[1]}, 4'h2);
        op_a(0, 13'd11, 2'b00); tick();
        op_a(1, 13'd12, 2'b01); tick();
        idle(); tick();
        chk("t3_doa_nc", 2, {2'b00, act_doa[2]}, 4'h3);
        chk("t3_doa_wf", 0, {2'b00, act_doa[0]}, 4'h1);

        // Collisions.
        op_a(1, 13'd8, 2'b11); op_b(1, 12'd4, 4'h0); tick();
        chk("t4_coll_ww", 0, {3'b000, act_coll[0]}, 4'h1);
        chk("t4_coll_none", 2, {3'b000, act_coll[2]}, 4'h0);
        op_a(1, 13'd12, 2'b10); op_b(1, 12'd4, 4'h0); tick();
        chk("t4_coll_disjoint", 0, {3'b000, act_coll[0]}, 4'h0);
        op_a(0, 13'd8, 2'b00); op_b(1, 12'd4, 4'hF); tick();
        chk("t4_doa_old", 0, {2'b00, act_doa[0]}, 4'h0);
        chk("t4_coll_rw", 0, {3'b000, act_coll[0]}, 4'h1);
        idle(); op_b(0, 12'd4, 4'h0); tick();
        chk("t4_dob_after", 0, act_dob[0], 4'hF);
        chk("t4_coll_rr_clear", 0, {3'b000, act_coll[0]}, 4'h0);

        // SSR with concurrent write, then reset blocking a write.
        idle(); op_a(1, 13'd20, 2'b01); ssra = 1; tick();
        chk("t5_doa_ssr", 0, {2'b00, act_doa[0]}, 4'h3);
        ssra = 0; op_a(0, 13'd20, 2'b00); tick();
        chk("t5_doa_mem", 0, {2'b00, act_doa[0]}, 4'h1);
        rst = 1; op_b(1, 12'd10, 4'hF); tick();
        chk("t5_rst_doa", 0, {2'b00, act_doa[0]}, 4'h0);
        chk("t5_rst_dob", 0, act_dob[0], 4'h0);
        chk("t5_rst_coll", 0, {3'b000, act_coll[0]}, 4'h0);
        chk("t5_rst_dob", 1, act_dob[1], 4'hA);
        rst = 0; idle(); op_b(0, 12'd10, 4'h0); tick();
        chk("t5_mem_kept", 0, act_dob[0], 4'b0001);

        // Output pipeline on port B of u1.
        idle(); op_b(0, 12'd5, 4'h0); tick();
        idle(); tick();
        chk("t6_dob_reg", 1, act_dob[1], 4'hC);
        op_b(0, 12'd10, 4'h0); tick();
        idle(); op_b(0, 12'd5, 4'h0); tick();
        idle(); rst = 1; tick();
        chk("t6_rst_dob", 1, act_dob[1], 4'hA);
        rst = 0; tick();
        chk("t6_no_stale", 1, act_dob[1], 4'hA);

        // SSR on port B.
        op_b(0, 12'd0, 4'h0); ssrb = 1; tick();
        chk("ssrb_dob", 2, act_dob[2], 4'h9);
        idle(); tick();
        chk("ssrb_dob_reg", 1, act_dob[1], 4'h6);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
